// File: rtl/cpu6_memarb.sv
// cpu6_memarb: shares one synchronous-read RAM port between data, fetch and external requesters.
// Optional starvation guard for the external master is built when CPU6_MEMARB_STARVE_EN is defined.
module cpu6_memarb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_req,
    input  logic          f_req,
    input  logic          x_req,
    input  logic          d_we,
    input  logic          x_we,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] f_addr,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [DW-1:0] x_wdata,
    input  logic          x_lock,
    output logic          d_gnt,
    output logic          f_gnt,
    output logic          x_gnt,
    output logic          d_rvalid,
    output logic          f_rvalid,
    output logic          x_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_D    = 2'd1,
        SEL_F    = 2'd2,
        SEL_X    = 2'd3
    } sel_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_t;

    sel_t  win_s;
    sel_t  rsel_r;
    sel_t  rsel_next_s;
    lock_t lock_r;
    lock_t lock_next_s;
    logic  starve_flag_s;

    // Winner selection; reset low masks every requester so nothing reaches the RAM.
    always_comb begin
        win_s = SEL_NONE;
        if (!reset) begin
            win_s = SEL_NONE;
        end else if (lock_r == LOCKED) begin
            if (x_req) begin
                win_s = SEL_X;
            end else begin
                win_s = SEL_NONE;
            end
        end else if (starve_flag_s && x_req) begin
            win_s = SEL_X;
        end else if (d_req) begin
            win_s = SEL_D;
        end else if (f_req) begin
            win_s = SEL_F;
        end else if (x_req) begin
            win_s = SEL_X;
        end else begin
            win_s = SEL_NONE;
        end
    end

    assign d_gnt  = (win_s == SEL_D);
    assign f_gnt  = (win_s == SEL_F);
    assign x_gnt  = (win_s == SEL_X);
    assign mem_en = (win_s != SEL_NONE);

    // RAM port mux; fetch is read-only so its write enable is pinned low.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        case (win_s)
            SEL_D: begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            SEL_F: begin
                mem_we    = 1'b0;
                mem_addr  = f_addr;
                mem_wdata = {DW{1'b0}};
            end
            SEL_X: begin
                mem_we    = x_we;
                mem_addr  = x_addr;
                mem_wdata = x_wdata;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = {AW{1'b0}};
                mem_wdata = {DW{1'b0}};
            end
        endcase
    end

    // Remember who issued this cycle's read so the returning data can be tagged.
    always_comb begin
        rsel_next_s = SEL_NONE;
        if (mem_en && !mem_we) begin
            rsel_next_s = win_s;
        end else begin
            rsel_next_s = SEL_NONE;
        end
    end

    // Read-return tag register; clearing it on reset drops any in-flight read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsel_r <= SEL_NONE;
        end else begin
            rsel_r <= rsel_next_s;
        end
    end

    assign d_rvalid = (rsel_r == SEL_D);
    assign f_rvalid = (rsel_r == SEL_F);
    assign x_rvalid = (rsel_r == SEL_X);
    assign rdata    = mem_rdata;

    // Lock next-state: external master holds the bus across x_lock beats.
    always_comb begin
        lock_next_s = lock_r;
        case (lock_r)
            UNLOCKED: begin
                if (x_gnt && x_lock) begin
                    lock_next_s = LOCKED;
                end else begin
                    lock_next_s = UNLOCKED;
                end
            end
            LOCKED: begin
                if (!x_req || (x_gnt && !x_lock)) begin
                    lock_next_s = UNLOCKED;
                end else begin
                    lock_next_s = LOCKED;
                end
            end
            default: begin
                lock_next_s = UNLOCKED;
            end
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_r <= UNLOCKED;
        end else begin
            lock_r <= lock_next_s;
        end
    end

`ifdef CPU6_MEMARB_STARVE_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_cnt_r;
    logic [7:0] starve_cnt_next_s;

    // Count cycles the external master waits; saturate instead of wrapping.
    always_comb begin
        starve_cnt_next_s = starve_cnt_r;
        if (!x_req || x_gnt) begin
            starve_cnt_next_s = 8'd0;
        end else if (starve_cnt_r != STARVE_LIM) begin
            starve_cnt_next_s = starve_cnt_r + 8'd1;
        end else begin
            starve_cnt_next_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= 8'd0;
        end else begin
            starve_cnt_r <= starve_cnt_next_s;
        end
    end

    assign starve_flag_s = (starve_cnt_r == STARVE_LIM);
`else
    // Guard absent: pure fixed priority, the limit only keeps the parameter referenced.
    assign starve_flag_s = 1'b0 & (STARVE_MAX != 0);
`endif

endmodule

// File: tb/tb_cpu6_memarb.sv
// Directed testbench for cpu6_memarb with a small synchronous-read RAM model.
module tb_cpu6_memarb;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          d_req, f_req, x_req;
    logic          d_we, x_we;
    logic [AW-1:0] d_addr, f_addr, x_addr;
    logic [DW-1:0] d_wdata, x_wdata;
    logic          x_lock;
    logic          d_gnt, f_gnt, x_gnt;
    logic          d_rvalid, f_rvalid, x_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [0:255];

    int n_total = 0;
    int n_bad   = 0;

    cpu6_memarb #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .d_req(d_req), .f_req(f_req), .x_req(x_req),
        .d_we(d_we), .x_we(x_we),
        .d_addr(d_addr), .f_addr(f_addr), .x_addr(x_addr),
        .d_wdata(d_wdata), .x_wdata(x_wdata),
        .x_lock(x_lock),
        .d_gnt(d_gnt), .f_gnt(f_gnt), .x_gnt(x_gnt),
        .d_rvalid(d_rvalid), .f_rvalid(f_rvalid), .x_rvalid(x_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: write at the edge, read data one cycle later.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 | 32'(i);
        mem_rdata = 32'h0;
        reset = 1'b0;
        d_req = 1'b1; f_req = 1'b1; x_req = 1'b1;
        d_we = 1'b0; x_we = 1'b0; x_lock = 1'b0;
        d_addr = 32'h10; f_addr = 32'h20; x_addr = 32'h30;
        d_wdata = 32'h0; x_wdata = 32'h0;

        // reset held low with every request high
        to_neg();
        chk("rst_dgnt", {31'b0, d_gnt}, 32'd0);
        chk("rst_fgnt", {31'b0, f_gnt}, 32'd0);
        chk("rst_xgnt", {31'b0, x_gnt}, 32'd0);
        chk("rst_memen", {31'b0, mem_en}, 32'd0);
        chk("rst_rvalid", {29'b0, d_rvalid, f_rvalid, x_rvalid}, 32'd0);
        to_pos();
        to_neg();
        chk("rst_rvalid2", {29'b0, d_rvalid, f_rvalid, x_rvalid}, 32'd0);

        // release: data wins immediately
        to_pos();
        reset = 1'b1;
        to_neg();
        chk("rel_dgnt", {31'b0, d_gnt}, 32'd1);
        chk("rel_fx_gnt", {30'b0, f_gnt, x_gnt}, 32'd0);
        chk("rel_addr", mem_addr, 32'h10);

        // in-flight read dropped by asynchronous reset
        to_pos();
        chk("inflight_rv", {31'b0, d_rvalid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("drop_rv", {31'b0, d_rvalid}, 32'd0);
        to_neg();
        chk("drop_memen", {31'b0, mem_en}, 32'd0);
        d_req = 1'b0; f_req = 1'b0; x_req = 1'b0;
        to_pos();
        reset = 1'b1;
        to_neg();
        chk("post_rst_rv", {29'b0, d_rvalid, f_rvalid, x_rvalid}, 32'd0);

        // concurrent read d(0x10) and f(0x20)
        to_pos();
        d_req = 1'b1; d_addr = 32'h10; f_req = 1'b1; f_addr = 32'h20;
        to_neg();
        chk("cc0_dgnt", {31'b0, d_gnt}, 32'd1);
        chk("cc0_fgnt", {31'b0, f_gnt}, 32'd0);
        chk("cc0_we", {31'b0, mem_we}, 32'd0);
        to_pos();
        d_req = 1'b0;
        to_neg();
        chk("cc1_drv", {31'b0, d_rvalid}, 32'd1);
        chk("cc1_rdata", rdata, 32'hA500_0010);
        chk("cc1_fgnt", {31'b0, f_gnt}, 32'd1);
        chk("cc1_addr", mem_addr, 32'h20);
        to_pos();
        f_req = 1'b0;
        to_neg();
        chk("cc2_frv", {31'b0, f_rvalid}, 32'd1);
        chk("cc2_drv", {31'b0, d_rvalid}, 32'd0);
        chk("cc2_rdata", rdata, 32'hA500_0020);
        chk("cc2_memen", {31'b0, mem_en}, 32'd0);

        // x writes 0xDEADBEEF to 0x40, f reads it back
        to_pos();
        x_req = 1'b1; x_we = 1'b1; x_addr = 32'h40; x_wdata = 32'hDEAD_BEEF;
        to_neg();
        chk("wr_xgnt", {31'b0, x_gnt}, 32'd1);
        chk("wr_we", {31'b0, mem_we}, 32'd1);
        chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        to_pos();
        x_req = 1'b0; f_req = 1'b1; f_addr = 32'h40;
        to_neg();
        chk("wr_no_rv", {29'b0, d_rvalid, f_rvalid, x_rvalid}, 32'd0);
        chk("rd_fgnt", {31'b0, f_gnt}, 32'd1);
        chk("rd_f_we0", {31'b0, mem_we}, 32'd0);
        to_pos();
        f_req = 1'b0; x_we = 1'b0;
        to_neg();
        chk("rd_frv", {31'b0, f_rvalid}, 32'd1);
        chk("rd_data", rdata, 32'hDEAD_BEEF);

        // lock: three external beats x_lock=1,1,0, d waiting from beat 2
        to_pos();
        x_req = 1'b1; x_lock = 1'b1; x_addr = 32'h50;
        to_neg();
        chk("lk1_xgnt", {31'b0, x_gnt}, 32'd1);
        to_pos();
        d_req = 1'b1; d_addr = 32'h11;
        to_neg();
        chk("lk2_xgnt", {31'b0, x_gnt}, 32'd1);
        chk("lk2_dgnt", {31'b0, d_gnt}, 32'd0);
        to_pos();
        x_lock = 1'b0;
        to_neg();
        chk("lk3_xgnt", {31'b0, x_gnt}, 32'd1);
        chk("lk3_dgnt", {31'b0, d_gnt}, 32'd0);
        chk("lk3_xrv", {31'b0, x_rvalid}, 32'd1);
        chk("lk3_rdata", rdata, 32'hA500_0050);
        to_pos();
        to_neg();
        chk("lk4_dgnt", {31'b0, d_gnt}, 32'd1);
        chk("lk4_xgnt", {31'b0, x_gnt}, 32'd0);
        to_pos();
        x_req = 1'b0; d_req = 1'b0;

        // lock dropped by one idle x_req cycle
        x_req = 1'b1; x_lock = 1'b1;
        to_neg();
        chk("ld0_xgnt", {31'b0, x_gnt}, 32'd1);
        to_pos();
        x_req = 1'b0; x_lock = 1'b0; d_req = 1'b1;
        to_neg();
        chk("ld1_dgnt", {31'b0, d_gnt}, 32'd0);
        chk("ld1_memen", {31'b0, mem_en}, 32'd0);
        to_pos();
        to_neg();
        chk("ld2_dgnt", {31'b0, d_gnt}, 32'd1);
        to_pos();
        d_req = 1'b0;
        to_neg();
        to_pos();

        // starvation: f and x held high for 20 cycles
        f_req = 1'b1; x_req = 1'b1; x_addr = 32'h60; f_addr = 32'h70;
        for (int c = 1; c <= 20; c++) begin
            logic exp_x;
            to_neg();
`ifdef CPU6_MEMARB_STARVE_EN
            exp_x = (c == 9) || (c == 18);
`else
            exp_x = 1'b0;
`endif
            chk($sformatf("sv%0d_xgnt", c), {31'b0, x_gnt}, {31'b0, exp_x});
            chk($sformatf("sv%0d_fgnt", c), {31'b0, f_gnt}, {31'b0, ~exp_x});
            to_pos();
        end
        f_req = 1'b0; x_req = 1'b0;
        to_neg();
        chk("end_memen", {31'b0, mem_en}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
